// File: rtl/pio_bank_if.sv
// Avalon-MM slave bus bundle for pio_bank: word address, one-cycle strobes,
// write data and the registered read data returned by the slave.
interface pio_bank_if #(
  parameter int DATA_W = 32
);
  logic [3:0]        address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (output address, read, write, writedata, input readdata);
  modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/pio_bank.sv
// Bank of Avalon-MM output/input channels with synchronized inputs.
// Define PIO_BANK_EDGE_IRQ_EN to add rising-edge capture, masks and irq.
module pio_bank #(
  parameter int DATA_W = 32,
  parameter int N_OUT  = 2,
  parameter int N_IN   = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  pio_bank_if.slave               bus,
  output logic [N_OUT*DATA_W-1:0] out_export,
  input  logic [N_IN*DATA_W-1:0]  in_export,
  output logic                    irq
);

  localparam logic [1:0] R_OUT = 2'd0;
  localparam logic [1:0] R_IN  = 2'd1;
`ifdef PIO_BANK_EDGE_IRQ_EN
  localparam logic [1:0] R_EDGE = 2'd2;
  localparam logic [1:0] R_MASK = 2'd3;
`endif

  logic [1:0] region;
  logic [1:0] k;
  assign region = bus.address[3:2];
  assign k      = bus.address[1:0];

  logic [N_OUT-1:0][DATA_W-1:0] out_q, out_d;
  logic [N_IN-1:0][DATA_W-1:0]  s1_q, s2_q;
  logic [DATA_W-1:0]            readdata_q, readdata_d;

`ifdef PIO_BANK_EDGE_IRQ_EN
  logic [N_IN-1:0][DATA_W-1:0]  s3_q;
  logic [N_IN-1:0][DATA_W-1:0]  edge_q, edge_d;
  logic [N_IN-1:0][DATA_W-1:0]  mask_q, mask_d;
  logic [N_IN-1:0][DATA_W-1:0]  rise;
  logic                         irq_q, irq_d;

  // Only genuine 0->1 transitions of the synchronized level count as edges.
  assign rise = s2_q & ~s3_q;
  assign irq  = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    out_d = out_q;
    for (int i = 0; i < N_OUT; i++) begin
      if (bus.write && region == R_OUT && k == 2'(i)) out_d[i] = bus.writedata;
    end

`ifdef PIO_BANK_EDGE_IRQ_EN
    mask_d = mask_q;
    for (int i = 0; i < N_IN; i++) begin
      // A new edge on a bit being cleared in the same cycle must survive.
      edge_d[i] = (edge_q[i] &
                   ~((bus.write && region == R_EDGE && k == 2'(i)) ?
                     bus.writedata : {DATA_W{1'b0}})) | rise[i];
      if (bus.write && region == R_MASK && k == 2'(i)) mask_d[i] = bus.writedata;
    end
    irq_d = |(edge_q & mask_q);
`endif

    readdata_d = readdata_q;
    if (bus.read) begin
      // Reads see pre-write register values; unmapped slots return 0.
      readdata_d = '0;
      for (int i = 0; i < N_OUT; i++) begin
        if (region == R_OUT && k == 2'(i)) readdata_d = out_q[i];
      end
      for (int i = 0; i < N_IN; i++) begin
        if (region == R_IN && k == 2'(i)) readdata_d = s2_q[i];
`ifdef PIO_BANK_EDGE_IRQ_EN
        if (region == R_EDGE && k == 2'(i)) readdata_d = edge_q[i];
        if (region == R_MASK && k == 2'(i)) readdata_d = mask_q[i];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_q      <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      readdata_q <= '0;
`ifdef PIO_BANK_EDGE_IRQ_EN
      s3_q       <= '0;
      edge_q     <= '0;
      mask_q     <= '0;
      irq_q      <= 1'b0;
`endif
    end else begin
      out_q      <= out_d;
      s1_q       <= in_export;
      s2_q       <= s1_q;
      readdata_q <= readdata_d;
`ifdef PIO_BANK_EDGE_IRQ_EN
      s3_q       <= s2_q;
      edge_q     <= edge_d;
      mask_q     <= mask_d;
      irq_q      <= irq_d;
`endif
    end
  end

  assign bus.readdata = readdata_q;

  generate
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_out
      assign out_export[gi*DATA_W +: DATA_W] = out_q[gi];
    end
  endgenerate

endmodule

// File: tb/tb_pio_bank.sv
// Self-checking bench for pio_bank (DATA_W=32, N_OUT=2, N_IN=2): vector table
// plus hand sequences; read results flow through an expected-value queue.
module tb_pio_bank;

  logic        clk;
  logic        reset_n;
  logic [63:0] out_export;
  logic [63:0] in_export;
  logic        irq;

  pio_bank_if #(.DATA_W(32)) bus_if ();

  pio_bank #(.DATA_W(32), .N_OUT(2), .N_IN(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus_if),
    .out_export (out_export),
    .in_export  (in_export),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          w;
    bit          r;
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic [63:0] exp_out;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] sb[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // One bus cycle: drive at negedge, DUT samples at posedge, check at next negedge.
  task automatic cyc(input bit w, input bit r, input logic [3:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input string tag);
    logic [31:0] e;
    bus_if.write     = w;
    bus_if.read      = r;
    bus_if.address   = a;
    bus_if.writedata = d;
    if (r) sb.push_back(exp_rd);
    @(posedge clk);
    @(negedge clk);
    bus_if.write = 1'b0;
    bus_if.read  = 1'b0;
    if (r) begin
      e = sb.pop_front();
      chk({tag, "_rd"}, {32'h0, bus_if.readdata}, {32'h0, e});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n          = 1'b0;
    in_export        = '0;
    bus_if.address   = '0;
    bus_if.read      = 1'b0;
    bus_if.write     = 1'b0;
    bus_if.writedata = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", out_export, 64'h0);
    chk("rst_rd", {32'h0, bus_if.readdata}, 64'h0);
    chk("rst_irq", {63'h0, irq}, 64'h0);
    reset_n = 1'b1;

    //          w  r  addr   wdata          exp_rd         exp_out
    tbl.push_back('{1, 0, 4'd0, 32'h12345678, 32'h0,        64'h00000000_12345678});
    tbl.push_back('{1, 0, 4'd1, 32'hDEADBEEF, 32'h0,        64'hDEADBEEF_12345678});
    tbl.push_back('{0, 1, 4'd1, 32'h0,        32'hDEADBEEF, 64'hDEADBEEF_12345678});
    tbl.push_back('{0, 1, 4'd0, 32'h0,        32'h12345678, 64'hDEADBEEF_12345678});
    tbl.push_back('{1, 0, 4'd3, 32'hFFFFFFFF, 32'h0,        64'hDEADBEEF_12345678});
    tbl.push_back('{0, 1, 4'd3, 32'h0,        32'h0,        64'hDEADBEEF_12345678});
    tbl.push_back('{1, 0, 4'd2, 32'h55555555, 32'h0,        64'hDEADBEEF_12345678});
    tbl.push_back('{0, 1, 4'd7, 32'h0,        32'h0,        64'hDEADBEEF_12345678});
    tbl.push_back('{1, 0, 4'd4, 32'h0000FFFF, 32'h0,        64'hDEADBEEF_12345678});
    tbl.push_back('{0, 1, 4'd4, 32'h0,        32'h0,        64'hDEADBEEF_12345678});
    tbl.push_back('{1, 1, 4'd0, 32'hCAFEF00D, 32'h12345678, 64'hDEADBEEF_CAFEF00D});
    tbl.push_back('{0, 1, 4'd0, 32'h0,        32'hCAFEF00D, 64'hDEADBEEF_CAFEF00D});
`ifndef PIO_BANK_EDGE_IRQ_EN
    tbl.push_back('{1, 0, 4'd12, 32'hFFFFFFFF, 32'h0,       64'hDEADBEEF_CAFEF00D});
    tbl.push_back('{0, 1, 4'd12, 32'h0,        32'h0,       64'hDEADBEEF_CAFEF00D});
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].exp_rd, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_out", i), out_export, tbl[i].exp_out);
    end

    // Input synchronizer latency: new value visible to a read sampled two edges later.
    in_export = 64'h00005A5A_0000A5A5;
    cyc(0, 1, 4'd4, 0, 32'h0,        "sync_e0");
    cyc(0, 1, 4'd4, 0, 32'h0,        "sync_e1");
    cyc(0, 1, 4'd4, 0, 32'h0000A5A5, "sync_e2");
    cyc(0, 1, 4'd5, 0, 32'h00005A5A, "sync_ch1");

    // Reset asserted during a write discards the write.
    in_export        = '0;
    reset_n          = 1'b0;
    bus_if.write     = 1'b1;
    bus_if.address   = 4'd0;
    bus_if.writedata = 32'h11111111;
    @(posedge clk);
    @(negedge clk);
    bus_if.write = 1'b0;
    chk("rst_wr_out", out_export, 64'h0);
    chk("rst_wr_rd", {32'h0, bus_if.readdata}, 64'h0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

`ifdef PIO_BANK_EDGE_IRQ_EN
    cyc(0, 1, 4'd8, 0, 32'h0, "edge_after_rst");
    cyc(1, 0, 4'd12, 32'h1, 0, "mask_wr");
    cyc(0, 1, 4'd12, 0, 32'h1, "mask_rd");
    in_export[0] = 1'b1;
    cyc(0, 0, 4'd0, 0, 0, "e0");
    chk("irq_e0", {63'h0, irq}, 64'h0);
    cyc(0, 0, 4'd0, 0, 0, "e1");
    chk("irq_e1", {63'h0, irq}, 64'h0);
    cyc(0, 1, 4'd8, 0, 32'h0, "edge_e2");
    chk("irq_e2", {63'h0, irq}, 64'h0);
    cyc(0, 1, 4'd8, 0, 32'h1, "edge_e3");
    chk("irq_e3", {63'h0, irq}, 64'h1);
    cyc(1, 0, 4'd8, 32'h1, 0, "clr");
    chk("irq_clr1", {63'h0, irq}, 64'h1);
    cyc(0, 0, 4'd0, 0, 0, "clr2");
    chk("irq_clr2", {63'h0, irq}, 64'h0);
    // Falling edge and steady level must not set EDGE.
    in_export[0] = 1'b0;
    repeat (4) cyc(0, 0, 4'd0, 0, 0, "fall");
    cyc(0, 1, 4'd8, 0, 32'h0, "fall_edge");
    chk("fall_irq", {63'h0, irq}, 64'h0);
    // Clear and new edge on bit 3 in the same cycle: edge wins.
    in_export[3] = 1'b1;
    cyc(0, 0, 4'd0, 0, 0, "b3_e0");
    cyc(0, 0, 4'd0, 0, 0, "b3_e1");
    cyc(1, 0, 4'd8, 32'h8, 0, "b3_clr");
    cyc(0, 1, 4'd8, 0, 32'h8, "b3_keep");
    chk("b3_irq", {63'h0, irq}, 64'h0);
    cyc(1, 0, 4'd14, 32'hFFFFFFFF, 0, "mask_unmapped_wr");
    cyc(0, 1, 4'd14, 0, 32'h0, "mask_unmapped");
    cyc(0, 1, 4'd10, 0, 32'h0, "edge_unmapped");
`else
    for (int t = 0; t < 6; t++) begin
      in_export = {$urandom, $urandom};
      cyc(0, 0, 4'd0, 0, 0, "toggle");
      chk($sformatf("irq_off%0d", t), {63'h0, irq}, 64'h0);
    end
    cyc(0, 1, 4'd8, 0, 32'h0, "edge_off");
    cyc(0, 1, 4'd12, 0, 32'h0, "mask_off");
    chk("irq_off_end", {63'h0, irq}, 64'h0);
`endif

    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
